// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the radix-2 FFT datapath.
//   DATA_WIDTH_DEF / TW_WIDTH_DEF : default data and twiddle component widths
//   F_IN_DEF / F_TW_DEF / F_OUT_DEF : default fractional bits (inputs, twiddle, outputs)
//   cplx_t : complex sample at the default data width (re in the upper half)
package fft_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int TW_WIDTH_DEF   = 16;
    localparam int F_IN_DEF       = 14;
    localparam int F_TW_DEF       = 14;
    localparam int F_OUT_DEF      = 13;

    localparam int CPLX_WIDTH = DATA_WIDTH_DEF;

    typedef struct packed {
        logic signed [CPLX_WIDTH-1:0] re;
        logic signed [CPLX_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_round_sat.sv
// fft_round_sat: round-half-up by SHIFT bits, then symmetric saturation to OUT_W bits.
//   din   : signed input, IN_W bits
//   dout  : signed result, OUT_W bits, never the most-negative code
//   clamp : 1 when the rounded value had to be saturated
module fft_round_sat #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clamp
);

    // One guard bit so adding the rounding half can never wrap.
    localparam int EW = IN_W + 1;
    localparam logic signed [EW-1:0] MAX_V = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = -MAX_V;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;

    assign ext = {din[IN_W-1], din};

    if (SHIFT > 0) begin : g_rnd
        localparam logic signed [EW-1:0] HALF = EW'(1) << (SHIFT - 1);
        logic signed [EW-1:0] biased;
        assign biased  = ext + HALF;
        assign shifted = biased >>> SHIFT;
    end else begin : g_no_rnd
        assign shifted = ext;
    end

    always_comb begin
        clamp = 1'b0;
        dout  = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            clamp = 1'b1;
            dout  = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            clamp = 1'b1;
            dout  = MIN_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/r2_pipe.sv
// r2_pipe: 3-stage pipelined radix-2 butterfly.
//   sum = a + b, dif = (a - b) * W  (or a - b when bypass_tw = 1)
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : input handshake; in_ready = !out_valid || out_ready
//   a_*, b_*, tw_*       : operands and twiddle (two's complement, F_IN / F_TW frac bits)
//   bypass_tw            : per-sample twiddle bypass
//   out_valid / out_ready: output handshake
//   sum_*, dif_*         : registered results at F_OUT frac bits, symmetric saturation
//   sat_flag / clr_sat   : sticky saturation flag and its synchronous clear
// F_OUT must not exceed F_IN.
module r2_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TW_WIDTH   = TW_WIDTH_DEF,
    parameter int F_IN       = F_IN_DEF,
    parameter int F_TW       = F_TW_DEF,
    parameter int F_OUT      = F_OUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a_r,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_r,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic signed [TW_WIDTH-1:0]   tw_r,
    input  logic signed [TW_WIDTH-1:0]   tw_i,
    input  logic                         bypass_tw,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] sum_r,
    output logic signed [DATA_WIDTH-1:0] sum_i,
    output logic signed [DATA_WIDTH-1:0] dif_r,
    output logic signed [DATA_WIDTH-1:0] dif_i,
    output logic                         sat_flag,
    input  logic                         clr_sat
);

    localparam int SW     = DATA_WIDTH + 1;
    localparam int PW     = DATA_WIDTH + 1 + TW_WIDTH + 1;
    localparam int SH_SUM = F_IN - F_OUT;
    localparam int SH_DIF = F_IN + F_TW - F_OUT;

    logic advance;

    logic                       s1_valid_q, s1_byp_q;
    logic signed [SW-1:0]       s1_sum_r_q, s1_sum_i_q, s1_dif_r_q, s1_dif_i_q;
    logic signed [TW_WIDTH-1:0] s1_tw_r_q, s1_tw_i_q;

    logic                       s2_valid_q;
    logic signed [SW-1:0]       s2_sum_r_q, s2_sum_i_q;
    logic signed [PW-1:0]       s2_dif_r_q, s2_dif_i_q;

    logic signed [PW-1:0]       p_rr, p_ii, p_ri, p_ir, dif_full_r, dif_full_i;
    logic signed [DATA_WIDTH-1:0] rs_sum_r, rs_sum_i, rs_dif_r, rs_dif_i;
    logic                       c_sum_r, c_sum_i, c_dif_r, c_dif_i;

    // Whole pipeline moves as one; a stall freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign p_rr = PW'(s1_dif_r_q) * PW'(s1_tw_r_q);
    assign p_ii = PW'(s1_dif_i_q) * PW'(s1_tw_i_q);
    assign p_ri = PW'(s1_dif_r_q) * PW'(s1_tw_i_q);
    assign p_ir = PW'(s1_dif_i_q) * PW'(s1_tw_r_q);

    // Bypassed samples are pre-scaled by F_TW so both dif paths share one rounding shift.
    always_comb begin
        if (s1_byp_q) begin
            dif_full_r = PW'(s1_dif_r_q) <<< F_TW;
            dif_full_i = PW'(s1_dif_i_q) <<< F_TW;
        end else begin
            dif_full_r = p_rr - p_ii;
            dif_full_i = p_ri + p_ir;
        end
    end

    fft_round_sat #(.IN_W(SW), .OUT_W(DATA_WIDTH), .SHIFT(SH_SUM)) u_rs_sum_r (
        .din(s2_sum_r_q), .dout(rs_sum_r), .clamp(c_sum_r)
    );
    fft_round_sat #(.IN_W(SW), .OUT_W(DATA_WIDTH), .SHIFT(SH_SUM)) u_rs_sum_i (
        .din(s2_sum_i_q), .dout(rs_sum_i), .clamp(c_sum_i)
    );
    fft_round_sat #(.IN_W(PW), .OUT_W(DATA_WIDTH), .SHIFT(SH_DIF)) u_rs_dif_r (
        .din(s2_dif_r_q), .dout(rs_dif_r), .clamp(c_dif_r)
    );
    fft_round_sat #(.IN_W(PW), .OUT_W(DATA_WIDTH), .SHIFT(SH_DIF)) u_rs_dif_i (
        .din(s2_dif_i_q), .dout(rs_dif_i), .clamp(c_dif_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_sum_r_q <= '0;
            s1_sum_i_q <= '0;
            s1_dif_r_q <= '0;
            s1_dif_i_q <= '0;
            s1_tw_r_q  <= '0;
            s1_tw_i_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_r_q <= '0;
            s2_sum_i_q <= '0;
            s2_dif_r_q <= '0;
            s2_dif_i_q <= '0;
            out_valid  <= 1'b0;
            sum_r      <= '0;
            sum_i      <= '0;
            dif_r      <= '0;
            dif_i      <= '0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            s1_byp_q   <= bypass_tw;
            s1_sum_r_q <= SW'(a_r) + SW'(b_r);
            s1_sum_i_q <= SW'(a_i) + SW'(b_i);
            s1_dif_r_q <= SW'(a_r) - SW'(b_r);
            s1_dif_i_q <= SW'(a_i) - SW'(b_i);
            s1_tw_r_q  <= tw_r;
            s1_tw_i_q  <= tw_i;
            s2_valid_q <= s1_valid_q;
            s2_sum_r_q <= s1_sum_r_q;
            s2_sum_i_q <= s1_sum_i_q;
            s2_dif_r_q <= dif_full_r;
            s2_dif_i_q <= dif_full_i;
            out_valid  <= s2_valid_q;
            sum_r      <= rs_sum_r;
            sum_i      <= rs_sum_i;
            dif_r      <= rs_dif_r;
            dif_i      <= rs_dif_i;
        end
    end

    // Only a valid sample actually moving into the output register may set the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (clr_sat) begin
            sat_flag <= 1'b0;
        end else if (advance && s2_valid_q && (c_sum_r || c_sum_i || c_dif_r || c_dif_i)) begin
            sat_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_r2_pipe.sv
module tb_r2_pipe;
    import fft_pkg::*;

    localparam int DW = 16;
    localparam int TWW = 16;
    localparam int FI = 14;
    localparam int FT = 14;
    localparam int FO = 13;
    localparam longint MAXV = 32767;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0, tw_r = '0, tw_i = '0;
    logic        bypass_tw = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum_r, sum_i, dif_r, dif_i;
    logic        sat_flag;
    logic        clr_sat = 1'b0;

    always #5 clk = ~clk;

    r2_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TWW), .F_IN(FI), .F_TW(FT), .F_OUT(FO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .tw_r(tw_r), .tw_i(tw_i),
        .bypass_tw(bypass_tw), .out_valid(out_valid), .out_ready(out_ready),
        .sum_r(sum_r), .sum_i(sum_i), .dif_r(dif_r), .dif_i(dif_i),
        .sat_flag(sat_flag), .clr_sat(clr_sat)
    );

    typedef struct {
        logic [15:0] sr, si, dr, di;
        bit          clamp;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Real-number semantics: floor(x / 2^s + 1/2).
    function automatic longint rhu(longint x, int s);
        longint d, n;
        if (s == 0) return x;
        d = longint'(1) << s;
        n = x + d / 2;
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic longint clampv(longint x);
        if (x > MAXV) return MAXV;
        if (x < -MAXV) return -MAXV;
        return x;
    endfunction

    function automatic exp_t model(logic [15:0] ar, ai, br, bi, wr, wi, logic byp);
        longint sr, si, d_r, d_i, yr, yi, w_r, w_i;
        exp_t   e;
        sr  = rhu(longint'($signed(ar)) + longint'($signed(br)), FI - FO);
        si  = rhu(longint'($signed(ai)) + longint'($signed(bi)), FI - FO);
        d_r = longint'($signed(ar)) - longint'($signed(br));
        d_i = longint'($signed(ai)) - longint'($signed(bi));
        w_r = longint'($signed(wr));
        w_i = longint'($signed(wi));
        if (byp) begin
            yr = rhu(d_r, FI - FO);
            yi = rhu(d_i, FI - FO);
        end else begin
            yr = rhu(d_r * w_r - d_i * w_i, FI + FT - FO);
            yi = rhu(d_r * w_i + d_i * w_r, FI + FT - FO);
        end
        e.clamp = (clampv(sr) != sr) || (clampv(si) != si) ||
                  (clampv(yr) != yr) || (clampv(yi) != yi);
        e.sr = 16'(clampv(sr));
        e.si = 16'(clampv(si));
        e.dr = 16'(clampv(yr));
        e.di = 16'(clampv(yi));
        return e;
    endfunction

    function automatic cplx_t cx(int re, int im);
        cplx_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    // Compare process: scoreboard against the model plus stall-stability checks.
    logic [15:0] h_sr, h_si, h_dr, h_di;
    bit          hold = 0;
    bit          clr_prev = 0;
    exp_t        e_cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_sum_r", {16'b0, sum_r}, {16'b0, h_sr});
                chk("stall_sum_i", {16'b0, sum_i}, {16'b0, h_si});
                chk("stall_dif_r", {16'b0, dif_r}, {16'b0, h_dr});
                chk("stall_dif_i", {16'b0, dif_i}, {16'b0, h_di});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: out_valid=1 with no sample in flight (t=%0t)",
                             $time);
                end else begin
                    e_cur = q.pop_front();
                    chk("sb_sum_r", {16'b0, sum_r}, {16'b0, e_cur.sr});
                    chk("sb_sum_i", {16'b0, sum_i}, {16'b0, e_cur.si});
                    chk("sb_dif_r", {16'b0, dif_r}, {16'b0, e_cur.dr});
                    chk("sb_dif_i", {16'b0, dif_i}, {16'b0, e_cur.di});
                    if (e_cur.clamp && !clr_prev) chk("sb_sat_flag", {31'b0, sat_flag}, 32'd1);
                end
            end
            hold = out_valid && !out_ready;
            h_sr = sum_r;
            h_si = sum_i;
            h_dr = dif_r;
            h_di = dif_i;
            if (in_valid && in_ready)
                q.push_back(model(a_r, a_i, b_r, b_i, tw_r, tw_i, bypass_tw));
        end
        clr_prev = clr_sat;
    end

    task automatic send(input cplx_t a, input cplx_t b, input cplx_t w, input logic byp);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        a_r = a.re;
        a_i = a.im;
        b_r = b.re;
        b_i = b.im;
        tw_r = w.re;
        tw_i = w.im;
        bypass_tw = byp;
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, expected 1");
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid && out_ready) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_out_timeout: out_valid=0 for 20 cycles, expected 1");
    endtask

    // Out_ready pattern 1,0,0,1 for the streaming test.
    bit pat_en = 0;
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pat_en) begin
                out_ready = ((k % 4) == 0) || ((k % 4) == 3);
                k++;
            end
        end
    end

    initial begin
        int lat;
        int n;
        cplx_t sa[8], sb[8], sw[8];
        logic  sbyp[8];

        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sat_flag", {31'b0, sat_flag}, 32'd0);
        chk("rst_sum_r", {16'b0, sum_r}, 32'h0);
        chk("rst_dif_i", {16'b0, dif_i}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 0.5 + 0.25 with W = 1
        send(cx(16'h2000, 0), cx(16'h1000, 0), cx(16'h4000, 0), 1'b0);
        wait_out(lat);
        chk("latency", 32'(lat), 32'd3);
        chk("w1_sum_r", {16'b0, sum_r}, 32'h1800);
        chk("w1_sum_i", {16'b0, sum_i}, 32'h0000);
        chk("w1_dif_r", {16'b0, dif_r}, 32'h0800);
        chk("w1_dif_i", {16'b0, dif_i}, 32'h0000);

        // W = -j
        send(cx(16'h2000, 0), cx(0, 0), cx(0, 16'hC000), 1'b0);
        wait_out(lat);
        chk("wmj_sum_r", {16'b0, sum_r}, 32'h1000);
        chk("wmj_dif_r", {16'b0, dif_r}, 32'h0000);
        chk("wmj_dif_i", {16'b0, dif_i}, 32'hF000);

        // Half-LSB rounds up; -half-LSB rounds up to zero
        send(cx(1, 0), cx(0, 0), cx(0, 0), 1'b1);
        wait_out(lat);
        chk("half_up_sum_r", {16'b0, sum_r}, 32'h0001);
        chk("half_up_dif_r", {16'b0, dif_r}, 32'h0001);
        send(cx(16'hFFFF, 0), cx(0, 0), cx(0, 0), 1'b1);
        wait_out(lat);
        chk("neg_half_sum_r", {16'b0, sum_r}, 32'h0000);

        // Largest positive sum fits exactly: no clamp
        send(cx(16'h7FFF, 0), cx(16'h7FFF, 0), cx(0, 0), 1'b1);
        wait_out(lat);
        chk("max_sum_r", {16'b0, sum_r}, 32'h7FFF);
        chk("max_dif_r", {16'b0, dif_r}, 32'h0000);
        chk("max_sat_flag", {31'b0, sat_flag}, 32'd0);

        // Most-negative sum clamps to -32767
        send(cx(16'h8000, 0), cx(16'h8000, 0), cx(0, 0), 1'b1);
        wait_out(lat);
        chk("neg_sat_sum_r", {16'b0, sum_r}, 32'h8001);
        chk("neg_sat_flag", {31'b0, sat_flag}, 32'd1);
        repeat (3) @(negedge clk);
        chk("sat_sticky", {31'b0, sat_flag}, 32'd1);
        @(posedge clk);
        #1 clr_sat = 1'b1;
        @(posedge clk);
        #1 clr_sat = 1'b0;
        @(negedge clk);
        chk("sat_cleared", {31'b0, sat_flag}, 32'd0);

        // Multiplied dif overflows positive
        send(cx(16'h7FFF, 0), cx(16'h8001, 0), cx(16'h7FFF, 0), 1'b0);
        wait_out(lat);
        chk("dif_sat_dif_r", {16'b0, dif_r}, 32'h7FFF);
        chk("dif_sat_sum_r", {16'b0, sum_r}, 32'h0000);
        chk("dif_sat_flag", {31'b0, sat_flag}, 32'd1);

        // Clear wins over a simultaneous set
        @(posedge clk);
        #1 clr_sat = 1'b1;
        send(cx(16'h8000, 0), cx(16'h8000, 0), cx(0, 0), 1'b1);
        wait_out(lat);
        @(negedge clk);
        chk("clr_priority", {31'b0, sat_flag}, 32'd0);
        @(posedge clk);
        #1 clr_sat = 1'b0;
        @(negedge clk);
        chk("clr_no_late_set", {31'b0, sat_flag}, 32'd0);

        // Stream of 8 under back-pressure
        for (int i = 0; i < 8; i++) begin
            sa[i] = cx(i * 4099 - 12000, 3000 - i * 777);
            sb[i] = cx(i * 555, -i * 2021);
            sw[i] = (i % 2 == 0) ? cx(16'h2D41, 16'hD2BF) : cx(16'hC000, 16'h1234);
            sbyp[i] = (i % 3 == 0);
        end
        @(posedge clk);
        #1 pat_en = 1;
        for (int i = 0; i < 8; i++) send(sa[i], sb[i], sw[i], sbyp[i]);
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stream_drained", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1 pat_en = 0;
        out_ready = 1'b1;

        // Reset with two samples in flight
        send(cx(16'h1111, 16'h2222), cx(16'h0333, 16'h0444), cx(16'h4000, 0), 1'b0);
        send(cx(16'h0555, 16'h0666), cx(16'h0777, 16'h0888), cx(16'h4000, 0), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sum_r", {16'b0, sum_r}, 32'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("no_stale_output", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end

        // Pipeline still works after the mid-run reset
        @(posedge clk);
        #1;
        send(cx(16'h2000, 0), cx(16'h1000, 0), cx(16'h4000, 0), 1'b0);
        wait_out(lat);
        chk("post_rst_sum_r", {16'b0, sum_r}, 32'h1800);
        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
